// File: rtl/bus_sequencer.sv
// Initiator of the shared tristate register bus: accepts one MV/MVI/ADD/SUB instruction per
// handshake and sequences the register, A and G strobes. Optional macro: BUS_SEQ_CONFLICT_CHECK_EN.
module bus_sequencer #(
  parameter int BUS_W = 3,
  parameter int NREG  = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SEL_W-1:0] rx,
  input  logic [SEL_W-1:0] ry,
  input  logic [BUS_W-1:0] imm,
  output logic             ready,
  output logic             done,
  output logic [NREG-1:0]  R_in,
  output logic [NREG-1:0]  R_out,
  output logic             A_in,
  output logic             G_in,
  output logic             G_out,
  output logic             alu_sub,
  inout  wire  [BUS_W-1:0] bus
`ifdef BUS_SEQ_CONFLICT_CHECK_EN
  ,
  output logic             bus_err
`endif
);

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [SEL_W-1:0] rx_q, rx_d;
  logic [SEL_W-1:0] ry_q, ry_d;
  logic [BUS_W-1:0] imm_q, imm_d;
  logic             imm_drv;

  // Out-of-range selects simply match no register, so no strobe is raised for them.
  function automatic logic [NREG-1:0] decode(input logic [SEL_W-1:0] sel);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel == SEL_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    imm_d   = imm_q;
    ready   = 1'b0;
    done    = 1'b0;
    R_in    = '0;
    R_out   = '0;
    A_in    = 1'b0;
    G_in    = 1'b0;
    G_out   = 1'b0;
    alu_sub = 1'b0;
    imm_drv = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          op_d    = op;
          rx_d    = rx;
          ry_d    = ry;
          imm_d   = imm;
          state_d = T1;
        end
      end
      T1: begin
        case (op_q)
          OP_MV: begin
            R_out   = decode(ry_q);
            R_in    = decode(rx_q);
            done    = 1'b1;
            state_d = IDLE;
          end
          OP_MVI: begin
            imm_drv = 1'b1;
            R_in    = decode(rx_q);
            done    = 1'b1;
            state_d = IDLE;
          end
          default: begin
            R_out   = decode(rx_q);
            A_in    = 1'b1;
            state_d = T2;
          end
        endcase
      end
      T2: begin
        R_out   = decode(ry_q);
        G_in    = 1'b1;
        alu_sub = op_q[0];
        state_d = T3;
      end
      T3: begin
        G_out   = 1'b1;
        R_in    = decode(rx_q);
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus = imm_drv ? imm_q : 'z;

`ifdef BUS_SEQ_CONFLICT_CHECK_EN
  localparam int DRV_W = NREG + 2;

  logic [DRV_W-1:0] drv_vec;
  logic             multi_drv;
  logic             orphan_load;
  logic             bus_err_q, bus_err_d;

  // Clearing the lowest set bit leaves something only when two or more drivers are enabled.
  always_comb begin
    drv_vec     = {R_out, G_out, imm_drv};
    multi_drv   = |(drv_vec & (drv_vec - DRV_W'(1)));
    orphan_load = ~|drv_vec & (|R_in | A_in | G_in);
    bus_err_d   = bus_err_q | multi_drv | orphan_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_err_q <= 1'b0;
    else     bus_err_q <= bus_err_d;
  end

  assign bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: a small register-file/ALU model sits on the bus and a
// scoreboard queue holds the expected strobe sequence and destination value of each instruction.
module tb_bus_sequencer;

  localparam int BW = 3;
  localparam int NR = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [SW-1:0] rx, ry;
  logic [BW-1:0] imm;
  logic          ready, done, A_in, G_in, G_out, alu_sub;
  logic [NR-1:0] R_in, R_out;
  wire  [BW-1:0] bus;

  logic          start2;
  logic [1:0]    op2;
  logic [SW-1:0] rx2, ry2;
  logic [BW-1:0] imm2;
  logic          ready2, done2, A_in2, G_in2, G_out2, alu_sub2;
  logic [2:0]    R_in2, R_out2;
  wire  [BW-1:0] bus2;

`ifdef BUS_SEQ_CONFLICT_CHECK_EN
  logic          bus_err, bus_err2;
`endif

  always #5 clk = ~clk;

  bus_sequencer #(.BUS_W(BW), .NREG(NR), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rx(rx), .ry(ry), .imm(imm),
    .ready(ready), .done(done), .R_in(R_in), .R_out(R_out), .A_in(A_in), .G_in(G_in),
    .G_out(G_out), .alu_sub(alu_sub), .bus(bus)
`ifdef BUS_SEQ_CONFLICT_CHECK_EN
    , .bus_err(bus_err)
`endif
  );

  // Second instance with only three registers so select value 3 is out of range.
  bus_sequencer #(.BUS_W(BW), .NREG(3), .SEL_W(SW)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op(op2), .rx(rx2), .ry(ry2), .imm(imm2),
    .ready(ready2), .done(done2), .R_in(R_in2), .R_out(R_out2), .A_in(A_in2), .G_in(G_in2),
    .G_out(G_out2), .alu_sub(alu_sub2), .bus(bus2)
`ifdef BUS_SEQ_CONFLICT_CHECK_EN
    , .bus_err(bus_err2)
`endif
  );

  typedef struct packed {
    logic [3:0] rIn;
    logic [3:0] rOut;
    logic       aIn;
    logic       gIn;
    logic       gOut;
    logic       aluSub;
    logic       done;
    logic       immDrv;
  } stepT;

  typedef struct packed {
    logic [1:0] idx;
    logic [2:0] val;
  } resT;

  stepT stepQ[$];
  resT  resQ[$];
  int   vecCount = 0;
  int   errCount = 0;

  logic [BW-1:0] regs [NR];
  logic [BW-1:0] aReg, gReg;
  logic          probeEn;
  logic [BW-1:0] probeVal;
  logic          tbEn;
  logic [BW-1:0] tbVal;

  // Register file and ALU model listening to the sequencer strobes
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (R_in[i]) regs[i] <= bus;
    end
    if (A_in) aReg <= bus;
    if (G_in) gReg <= alu_sub ? aReg - bus : aReg + bus;
  end

  // The probe value occupies the bus whenever nothing should drive it, exposing a stray DUT drive
  always_comb begin
    tbEn  = 1'b0;
    tbVal = '0;
    if (R_out != '0) begin
      tbEn = 1'b1;
      for (int i = 0; i < NR; i++) begin
        if (R_out[i]) tbVal = regs[i];
      end
    end else if (G_out) begin
      tbEn  = 1'b1;
      tbVal = gReg;
    end else if (probeEn) begin
      tbEn  = 1'b1;
      tbVal = probeVal;
    end
  end

  assign bus = tbEn ? tbVal : 'z;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [1:0] x, input logic [1:0] y,
                               input logic [2:0] im, input logic [2:0] expVal, input bit hold);
    stepT s;
    resT  r;
    logic [3:0] ohX, ohY;
    op = o; rx = x; ry = y; imm = im; start = 1'b1;
    probeVal = ~im;
    ohX = 4'b0001 << x;
    ohY = 4'b0001 << y;
    case (o)
      2'b00: begin
        s = '0; s.rIn = ohX; s.rOut = ohY; s.done = 1'b1; stepQ.push_back(s);
      end
      2'b01: begin
        s = '0; s.rIn = ohX; s.immDrv = 1'b1; s.done = 1'b1; stepQ.push_back(s);
      end
      default: begin
        s = '0; s.rOut = ohX; s.aIn = 1'b1; stepQ.push_back(s);
        s = '0; s.rOut = ohY; s.gIn = 1'b1; s.aluSub = o[0]; stepQ.push_back(s);
        s = '0; s.gOut = 1'b1; s.rIn = ohX; s.done = 1'b1; stepQ.push_back(s);
      end
    endcase
    r.idx = x; r.val = expVal;
    resQ.push_back(r);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    while (stepQ.size() > 0) begin
      stepT e;
      logic [12:0] act, expv;
      e = stepQ.pop_front();
      probeEn = !e.immDrv;
      @(negedge clk);
      act  = {R_in, R_out, A_in, G_in, G_out, alu_sub, done};
      expv = {e.rIn, e.rOut, e.aIn, e.gIn, e.gOut, e.aluSub, e.done};
      vecCount++;
      if (act !== expv) begin
        errCount++;
        $display("[TB] FAIL strobes op=%b: got %b want %b", o, act, expv);
      end
      vecCount++;
      if (ready !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL busy_ready op=%b: got %b want 0", o, ready);
      end
      if (e.immDrv) begin
        vecCount++;
        if (bus !== im) begin
          errCount++;
          $display("[TB] FAIL imm_drive: got %b want %b", bus, im);
        end
      end else if (e.rOut == '0 && !e.gOut) begin
        vecCount++;
        if (bus !== ~im) begin
          errCount++;
          $display("[TB] FAIL bus_release op=%b: got %b want %b", o, bus, ~im);
        end
      end
      @(posedge clk); #1;
    end
    probeEn = 1'b1;
    r = resQ.pop_front();
    vecCount++;
    if (regs[r.idx] !== r.val) begin
      errCount++;
      $display("[TB] FAIL result R%0d: got %b want %b", r.idx, regs[r.idx], r.val);
    end
    vecCount++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL idle_after op=%b: got ready=%b done=%b want ready=1 done=0", o, ready, done);
    end
  endtask

  task automatic test_reset();
    logic [12:0] act;
    start = 1'b0; op = '0; rx = '0; ry = '0; imm = '0;
    start2 = 1'b0; op2 = '0; rx2 = '0; ry2 = '0; imm2 = '0;
    probeEn = 1'b1; probeVal = 3'b010;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    act = {R_in, R_out, A_in, G_in, G_out, alu_sub, done};
    vecCount++;
    if (act !== 13'b0 || ready !== 1'b1 || bus !== 3'b010) begin
      errCount++;
      $display("[TB] FAIL reset_state: got strobes=%b ready=%b bus=%b want 0/1/010", act, ready, bus);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    op = 2'b10; rx = 2'd1; ry = 2'd2; imm = 3'b101; probeVal = 3'b010; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    vecCount++;
    if (R_out !== 4'b0010 || A_in !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL reset_pre_T1: got R_out=%b A_in=%b want 0010/1", R_out, A_in);
    end
    @(posedge clk); #1;
    vecCount++;
    if (R_out !== 4'b0100 || G_in !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL reset_pre_T2: got R_out=%b G_in=%b want 0100/1", R_out, G_in);
    end
    #2; rst = 1'b1; #1;
    act = {R_in, R_out, A_in, G_in, G_out, alu_sub, done};
    vecCount++;
    if (act !== 13'b0 || ready !== 1'b1 || bus !== 3'b010) begin
      errCount++;
      $display("[TB] FAIL reset_async: got strobes=%b ready=%b bus=%b want 0/1/010", act, ready, bus);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vecCount++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL reset_no_done: got done=%b ready=%b want 0/1", done, ready);
    end
  endtask

  task automatic test_mvi();
    @(negedge clk); applyStimulus(2'b01, 2'd2, 2'd0, 3'b101, 3'b101, 1'b0);
  endtask

  task automatic test_mv();
    @(negedge clk); applyStimulus(2'b00, 2'd0, 2'd2, 3'b011, 3'b101, 1'b0);
    @(negedge clk); applyStimulus(2'b00, 2'd2, 2'd2, 3'b110, 3'b101, 1'b0);
  endtask

  task automatic test_add();
    @(negedge clk); applyStimulus(2'b01, 2'd1, 2'd0, 3'b011, 3'b011, 1'b0);
    @(negedge clk); applyStimulus(2'b01, 2'd2, 2'd0, 3'b010, 3'b010, 1'b0);
    @(negedge clk); applyStimulus(2'b10, 2'd1, 2'd2, 3'b001, 3'b101, 1'b0);
  endtask

  task automatic test_sub_hold();
    @(negedge clk); applyStimulus(2'b01, 2'd3, 2'd0, 3'b111, 3'b111, 1'b0);
    @(negedge clk); applyStimulus(2'b11, 2'd1, 2'd3, 3'b001, 3'b110, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    vecCount++;
    if (ready !== 1'b1 || done !== 1'b0 || R_in !== 4'b0000) begin
      errCount++;
      $display("[TB] FAIL no_queue: got ready=%b done=%b R_in=%b want 1/0/0000", ready, done, R_in);
    end
    @(negedge clk); applyStimulus(2'b10, 2'd3, 2'd3, 3'b001, 3'b110, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk); applyStimulus(2'b01, 2'd0, 2'd0, 3'b100, 3'b100, 1'b1);
    @(negedge clk); applyStimulus(2'b00, 2'd1, 2'd0, 3'b001, 3'b100, 1'b0);
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    op2 = 2'b00; rx2 = 2'd3; ry2 = 2'd3; imm2 = 3'b001; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    vecCount++;
    if ({R_in2, R_out2, A_in2, G_in2, G_out2} !== 9'b0 || done2 !== 1'b1 || ready2 !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL oor_mv: got R_in=%b R_out=%b done=%b ready=%b want 000/000/1/0",
               R_in2, R_out2, done2, ready2);
    end
    @(posedge clk); #1;
    vecCount++;
    if (ready2 !== 1'b1 || done2 !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL oor_idle: got ready=%b done=%b want 1/0", ready2, done2);
    end
`ifdef BUS_SEQ_CONFLICT_CHECK_EN
    vecCount++;
    if (bus_err2 !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL oor_err_quiet: got %b want 0", bus_err2);
    end
`endif
    @(negedge clk);
    op2 = 2'b10; rx2 = 2'd0; ry2 = 2'd3; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    @(posedge clk); #1;
    vecCount++;
    if (R_out2 !== 3'b000 || G_in2 !== 1'b1 || alu_sub2 !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL oor_add_T2: got R_out=%b G_in=%b sub=%b want 000/1/0", R_out2, G_in2, alu_sub2);
    end
    @(posedge clk); #1;
    vecCount++;
    if (R_in2 !== 3'b001 || G_out2 !== 1'b1 || done2 !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL oor_add_T3: got R_in=%b G_out=%b done=%b want 001/1/1", R_in2, G_out2, done2);
    end
    @(posedge clk); #1;
  endtask

`ifdef BUS_SEQ_CONFLICT_CHECK_EN
  task automatic test_conflict();
    vecCount++;
    if (bus_err !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL conflict_clean: got %b want 0", bus_err);
    end
    vecCount++;
    if (bus_err2 !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL conflict_orphan_load: got %b want 1", bus_err2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mvi();
    test_mv();
    test_add();
    test_sub_hold();
    test_back_to_back();
    test_out_of_range();
`ifdef BUS_SEQ_CONFLICT_CHECK_EN
    test_conflict();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
